// File: rtl/conntb_stim_checker_if.sv
// ConnectTB link between the stimulus/checker stage and the DUT stage.
// drive carries serialised stimulus toward the DUT; observe carries its response back.
interface conntb_stim_checker_if;
  logic drive;
  logic observe;

  // Stimulus side: owns drive, samples observe.
  modport tb (
    output drive,
    input  observe
  );

  // DUT side: consumes drive, produces observe.
  modport dut (
    input  drive,
    output observe
  );

  modport master (
    output drive,
    input  observe
  );

  modport slave (
    input  drive,
    output observe
  );
endinterface

// File: rtl/conntb_stim_checker.sv
// Serialises a latched pattern onto intf.drive LSB first, compares intf.observe against the
// drive history delayed by LATENCY cycles, and reports the mismatch count and a pass flag.
module conntb_stim_checker #(
  parameter  int NUM_BITS = 16,
  parameter  int LATENCY  = 0,
  localparam int CW       = $clog2(NUM_BITS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  conntb_stim_checker_if.tb   intf,
  input  logic                start,
  input  logic [NUM_BITS-1:0] pattern,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CW-1:0]       err_count,
  output logic [CW-1:0]       bit_count
);

  // Cycle index spans the drive phase plus the drain phase.
  localparam int KW = $clog2(NUM_BITS + LATENCY + 1);
  localparam int HW = (LATENCY > 0) ? LATENCY : 1;
  localparam int LI = (LATENCY > 0) ? LATENCY - 1 : 0;

  localparam logic [KW-1:0] LAST_RUN   = KW'(NUM_BITS - 1);
  localparam logic [KW-1:0] LAST_DRAIN = KW'(NUM_BITS + LATENCY - 1);
  localparam logic [KW-1:0] FIRST_CMP  = KW'(LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic                drive_q, drive_d;
  logic [HW-1:0]       hist_q,  hist_d;
  logic [KW-1:0]       cnt_q,   cnt_d;
  logic [CW-1:0]       err_q,   err_d;
  logic [CW-1:0]       bits_q,  bits_d;
  logic                pass_q,  pass_d;

  logic                compare;
  logic                expected;

  // hist_q[i] holds the bit driven i+1 cycles ago; with no latency the live drive bit is the reference.
  assign expected = (LATENCY == 0) ? drive_q : hist_q[LI];

  // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    drive_d = drive_q;
    hist_d  = hist_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    bits_d  = bits_q;
    pass_d  = pass_q;
    compare = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = pattern >> 1;
          drive_d = pattern[0];
          hist_d  = '0;
          cnt_d   = '0;
          err_d   = '0;
          bits_d  = '0;
          pass_d  = 1'b0;
          state_d = RUN;
        end
      end

      RUN: begin
        drive_d = shift_q[0];
        shift_d = shift_q >> 1;
        hist_d  = HW'({hist_q, drive_q});
        cnt_d   = cnt_q + KW'(1);
        compare = (cnt_q >= FIRST_CMP);
        if (cnt_q == LAST_RUN) begin
          drive_d = 1'b0;
          state_d = (LATENCY > 0) ? DRAIN : DONE;
        end
      end

      DRAIN: begin
        drive_d = 1'b0;
        hist_d  = HW'({hist_q, drive_q});
        cnt_d   = cnt_q + KW'(1);
        compare = 1'b1;
        if (cnt_q == LAST_DRAIN) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (compare) begin
      bits_d = bits_q + CW'(1);
      if (intf.observe != expected) begin
        err_d = err_q + CW'(1);
      end
    end

    // The final comparison lands on the same edge as the move to DONE, so judge the updated count.
    if (state_d == DONE && state_q != DONE) begin
      pass_d = (err_d == '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      drive_q <= 1'b0;
      hist_q  <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      bits_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      drive_q <= drive_d;
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      bits_q  <= bits_d;
      pass_q  <= pass_d;
    end
  end

  assign intf.drive = drive_q;
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign bit_count  = bits_q;

endmodule

// File: tb/tb_conntb_stim_checker.sv
// Bench for conntb_stim_checker: a zero-latency unit with selectable loopback/stuck/inverting path
// and a LATENCY=2 unit behind a two-flop path, driven from a vector table plus a mid-run reset sequence.
module tb_conntb_stim_checker;

  localparam int NB = 16;
  localparam int CWT = $clog2(NB + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]    start_v = '0;
  logic [NB-1:0] pat_s [2];
  logic [1:0]    busy_v, done_v, pass_v;
  logic [CWT-1:0] err_v [2];
  logic [CWT-1:0] bits_v [2];
  logic [1:0]    drv;
  int            mode_v [2];
  logic          d1 = 1'b0, d2 = 1'b0;

  conntb_stim_checker_if intf0 ();
  conntb_stim_checker_if intf1 ();

  // Unit 0 path: 0 = loopback, 1 = stuck at 0, 2 = inverting.
  assign intf0.observe = (mode_v[0] == 0) ? intf0.drive :
                         (mode_v[0] == 1) ? 1'b0 : ~intf0.drive;

  // Unit 1 path: two-flop delay, or stuck at 0.
  always @(posedge clk) begin
    d1 <= intf1.drive;
    d2 <= d1;
  end
  assign intf1.observe = (mode_v[1] == 0) ? d2 : 1'b0;

  assign drv = {intf1.drive, intf0.drive};

  conntb_stim_checker #(.NUM_BITS(NB), .LATENCY(0)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .intf      (intf0),
    .start     (start_v[0]),
    .pattern   (pat_s[0]),
    .busy      (busy_v[0]),
    .done      (done_v[0]),
    .pass      (pass_v[0]),
    .err_count (err_v[0]),
    .bit_count (bits_v[0])
  );

  conntb_stim_checker #(.NUM_BITS(NB), .LATENCY(2)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .intf      (intf1),
    .start     (start_v[1]),
    .pattern   (pat_s[1]),
    .busy      (busy_v[1]),
    .done      (done_v[1]),
    .pass      (pass_v[1]),
    .err_count (err_v[1]),
    .bit_count (bits_v[1])
  );

  typedef struct {
    int          unit;
    int          mode;
    logic [15:0] pat;
    bit          poke_run;
    bit          poke_done;
    int          exp_err;
    bit          exp_pass;
  } vec_t;

  typedef struct {
    int err;
    int bits;
    bit pass;
    int cycles;
  } sb_t;

  sb_t  sb_q [$];
  vec_t vecs [9];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int  u, lat, cyc, bad;
    bit  seen;
    sb_t e;
    string tag;
    u   = v.unit;
    lat = (u == 1) ? 2 : 0;
    tag = $sformatf("u%0d_%04h", u, v.pat);
    mode_v[u]  = v.mode;
    pat_s[u]   = v.pat;
    start_v[u] = 1'b1;
    sb_q.push_back('{err: v.exp_err, bits: NB, pass: v.exp_pass, cycles: 17 + lat});
    cyc  = 0;
    bad  = 0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start_v[u] = 1'b0;
      if (v.poke_run && cyc == 4) begin
        start_v[u] = 1'b1;
        pat_s[u]   = 16'hFFFF;
      end
      if (v.poke_run && cyc == 5) start_v[u] = 1'b0;
      if (cyc <= NB) begin
        if (drv[u] !== v.pat[cyc-1] || busy_v[u] !== 1'b1) bad++;
      end else if (cyc <= NB + lat) begin
        if (drv[u] !== 1'b0 || busy_v[u] !== 1'b1) bad++;
      end
      if (done_v[u] === 1'b1) seen = 1'b1;
    end
    check({tag, "_drive_seq"}, bad, 0);
    e = sb_q.pop_front();
    if (!seen) begin
      check({tag, "_done_timeout"}, 0, 1);
    end else begin
      check({tag, "_err_count"}, err_v[u], e.err);
      check({tag, "_bit_count"}, bits_v[u], e.bits);
      check({tag, "_pass"}, pass_v[u], e.pass);
      check({tag, "_done_cycle"}, cyc, e.cycles);
      check({tag, "_busy_at_done"}, busy_v[u], 0);
    end
    if (v.poke_done) start_v[u] = 1'b1;
    @(negedge clk);
    start_v[u] = 1'b0;
    check({tag, "_done_pulse_len"}, done_v[u], 0);
    check({tag, "_idle_after"}, busy_v[u], 0);
    check({tag, "_pass_held"}, pass_v[u], e.pass);
  endtask

  initial begin
    int cyc;
    int stray;
    pat_s[0]  = '0;
    pat_s[1]  = '0;
    mode_v[0] = 0;
    mode_v[1] = 0;

    vecs[0] = '{unit: 0, mode: 0, pat: 16'hA5A5, poke_run: 0, poke_done: 0, exp_err: 0,  exp_pass: 1};
    vecs[1] = '{unit: 0, mode: 1, pat: 16'hA5A5, poke_run: 0, poke_done: 0, exp_err: 8,  exp_pass: 0};
    vecs[2] = '{unit: 0, mode: 2, pat: 16'h0000, poke_run: 0, poke_done: 0, exp_err: 16, exp_pass: 0};
    vecs[3] = '{unit: 0, mode: 0, pat: 16'h0000, poke_run: 0, poke_done: 0, exp_err: 0,  exp_pass: 1};
    vecs[4] = '{unit: 1, mode: 0, pat: 16'h8001, poke_run: 0, poke_done: 0, exp_err: 0,  exp_pass: 1};
    vecs[5] = '{unit: 0, mode: 0, pat: 16'h1234, poke_run: 1, poke_done: 0, exp_err: 0,  exp_pass: 1};
    vecs[6] = '{unit: 0, mode: 1, pat: 16'hF00F, poke_run: 0, poke_done: 1, exp_err: 8,  exp_pass: 0};
    vecs[7] = '{unit: 1, mode: 1, pat: 16'h00FF, poke_run: 0, poke_done: 0, exp_err: 8,  exp_pass: 0};
    vecs[8] = '{unit: 1, mode: 0, pat: 16'hC35A, poke_run: 0, poke_done: 0, exp_err: 0,  exp_pass: 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("u%0d_reset_drive", u), drv[u], 0);
      check($sformatf("u%0d_reset_busy", u), busy_v[u], 0);
      check($sformatf("u%0d_reset_done", u), done_v[u], 0);
      check($sformatf("u%0d_reset_pass", u), pass_v[u], 0);
      check($sformatf("u%0d_reset_err", u), err_v[u], 0);
      check($sformatf("u%0d_reset_bits", u), bits_v[u], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run(vecs[i]);

    // Mid-run reset: abort while bit 5 is on the wire.
    mode_v[0]  = 0;
    pat_s[0]   = 16'hA5A5;
    start_v[0] = 1'b1;
    cyc = 0;
    while (cyc < 6) begin
      @(negedge clk);
      cyc++;
      start_v[0] = 1'b0;
    end
    check("midrst_busy_before", busy_v[0], 1);
    check("midrst_bits_before", bits_v[0], 5);
    check("midrst_drive_before", drv[0], 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_drive", drv[0], 0);
    check("midrst_busy", busy_v[0], 0);
    check("midrst_err", err_v[0], 0);
    check("midrst_bits", bits_v[0], 0);
    check("midrst_done", done_v[0], 0);
    rst = 1'b0;
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) stray++;
    end
    check("midrst_no_done", stray, 0);

    run('{unit: 0, mode: 0, pat: 16'h5A5A, poke_run: 0, poke_done: 0, exp_err: 0, exp_pass: 1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
